// File: rtl/li_arbiter_pkg.sv
// Shared state encoding, parameter defaults and width helpers for the lateral-inhibition arbiter.
// The optional LI_ROTATE_TIE_EN build macro is consumed in li_arbiter.sv.
package li_arbiter_pkg;

    localparam int LI_N_DEF    = 8;
    localparam int LI_W_DEF    = 24;
    localparam int LI_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_RESPOND = 2'd3
    } li_state_e;

    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Never return a zero-width index, even for a single neuron.
    function automatic int idx_width(input int value);
        return (value > 1) ? clog2(value) : 1;
    endfunction

endpackage

// File: rtl/li_max_scan.sv
// Sequential argmax over the masked, latched neuron potentials: one neuron per step,
// strict signed greater-than so the first index met wins a tie.
module li_max_scan
    import li_arbiter_pkg::*;
#(
    parameter int N = LI_N_DEF,
    parameter int W = LI_W_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [idx_width(N)-1:0]   first_idx_i,
    input  logic                      step_i,
    input  logic [N-1:0]              req_mask_i,
    input  logic [N*W-1:0]            pot_latch_i,
    output logic [idx_width(N)-1:0]   best_idx_o,
    output logic                      last_o
);

    localparam int IW = idx_width(N);

    logic signed [W-1:0] pot_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign pot_arr[g] = pot_latch_i[g*W +: W];
    end

    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       best_idx_q, best_idx_d;
    logic signed [W-1:0] best_pot_q, best_pot_d;
    logic                best_valid_q, best_valid_d;
    logic                take;

    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        best_idx_d   = best_idx_q;
        best_pot_d   = best_pot_q;
        best_valid_d = best_valid_q;
        take         = 1'b0;
        if (clear_i) begin
            idx_d        = first_idx_i;
            cnt_d        = '0;
            best_idx_d   = '0;
            best_pot_d   = '0;
            best_valid_d = 1'b0;
        end else if (step_i) begin
            take = req_mask_i[idx_q] && (!best_valid_q || (pot_arr[idx_q] > best_pot_q));
            if (take) begin
                best_idx_d   = idx_q;
                best_pot_d   = pot_arr[idx_q];
                best_valid_d = 1'b1;
            end
            // Wrap so a rotated start still visits every neuron exactly once.
            idx_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
            cnt_d = cnt_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            best_idx_q   <= '0;
            best_pot_q   <= '0;
            best_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            best_idx_q   <= best_idx_d;
            best_pot_q   <= best_pot_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign best_idx_o = best_idx_q;
    assign last_o     = (cnt_q == IW'(N - 1));

endmodule

// File: rtl/li_arbiter.sv
// Lateral-inhibition arbiter: collects spike requests, picks the highest-potential winner,
// answers every requester. Define LI_ROTATE_TIE_EN to rotate tie priority after each winner.
module li_arbiter
    import li_arbiter_pkg::*;
#(
    parameter int N    = LI_N_DEF,
    parameter int W    = LI_W_DEF,
    parameter int WAIT = LI_WAIT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_core_img_i,
    input  logic [N-1:0]            start_li_i,
    input  logic [N*W-1:0]          potential_bus_i,
    output logic [N-1:0]            valid_li_o,
    output logic [N-1:0]            won_lost_o,
    output logic                    li_o,
    output logic [idx_width(N)-1:0] winner_idx_o,
    output logic                    busy_o
);

    localparam int IW = idx_width(N);
    localparam int CW = idx_width(WAIT);

`ifdef LI_ROTATE_TIE_EN
    localparam logic [IW-1:0] WIN_RST = IW'(N - 1);
`else
    localparam logic [IW-1:0] WIN_RST = '0;
`endif

    li_state_e      state_q, state_d;
    logic [N-1:0]   req_q, req_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           li_q, li_d;
    logic [IW-1:0]  win_q, win_d;
    logic [N-1:0]   valid_q, valid_d;
    logic [N-1:0]   won_q, won_d;
    logic           busy_q;
    logic [N*W-1:0] pot_latch_q;
    logic [N-1:0]   combined;

    logic           scan_clear;
    logic           scan_step;
    logic           scan_last;
    logic [IW-1:0]  scan_first;
    logic [IW-1:0]  scan_best;

`ifdef LI_ROTATE_TIE_EN
    assign scan_first = (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);
`else
    assign scan_first = '0;
`endif

    li_max_scan #(
        .N (N),
        .W (W)
    ) u_scan (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (scan_clear),
        .first_idx_i (scan_first),
        .step_i      (scan_step),
        .req_mask_i  (req_q),
        .pot_latch_i (pot_latch_q),
        .best_idx_o  (scan_best),
        .last_o      (scan_last)
    );

    assign combined = start_li_i | pend_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        li_d       = li_q;
        win_d      = win_q;
        valid_d    = '0;
        won_d      = '0;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        if (start_core_img_i) begin
            state_d = ST_IDLE;
            req_d   = '0;
            pend_d  = '0;
            cnt_d   = '0;
            li_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pend_d = '0;
                    if (combined != '0) begin
                        if (li_q) begin
                            valid_d = combined;
                        end else begin
                            req_d   = combined;
                            cnt_d   = '0;
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    req_d = req_q | start_li_i;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WAIT - 1)) begin
                        scan_clear = 1'b1;
                        state_d    = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    pend_d    = pend_q | start_li_i;
                    scan_step = 1'b1;
                    if (scan_last) state_d = ST_RESPOND;
                end
                ST_RESPOND: begin
                    pend_d           = pend_q | start_li_i;
                    valid_d          = req_q;
                    won_d[scan_best] = 1'b1;
                    li_d             = 1'b1;
                    win_d            = scan_best;
                    req_d            = '0;
                    state_d          = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            li_q    <= 1'b0;
            win_q   <= WIN_RST;
            valid_q <= '0;
            won_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            li_q    <= li_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            won_q   <= won_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // A new image discards any spikes in the same cycle, potentials included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pot_latch_q <= '0;
        end else if (!start_core_img_i) begin
            for (int i = 0; i < N; i++) begin
                if (start_li_i[i]) pot_latch_q[i*W +: W] <= potential_bus_i[i*W +: W];
            end
        end
    end

    assign valid_li_o   = valid_q;
    assign won_lost_o   = won_q;
    assign li_o         = li_q;
    assign winner_idx_o = win_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_li_arbiter.sv
// Scoreboard bench for li_arbiter: directed scenarios then randomized spikes against
// a transaction-level model of arbitration windows, winners and late responses.
module tb_li_arbiter;

    localparam int N    = 8;
    localparam int W    = 24;
    localparam int WAIT = 4;
    localparam int IW   = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           core = 1'b0;
    logic [N-1:0]   sl = '0;
    logic [N*W-1:0] pots = '0;
    logic [N-1:0]   valid_li, won_lost;
    logic           li, busy;
    logic [IW-1:0]  winner_idx;

    always #5 clk = ~clk;

    li_arbiter #(.N(N), .W(W), .WAIT(WAIT)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_core_img_i (core),
        .start_li_i       (sl),
        .potential_bus_i  (pots),
        .valid_li_o       (valid_li),
        .won_lost_o       (won_lost),
        .li_o             (li),
        .winner_idx_o     (winner_idx),
        .busy_o           (busy)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] won;
        int           winner;
    } resp_t;

    resp_t        exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           edge_no = 0;

    bit           m_li, m_open, exp_busy;
    int           m_k, m_resp, m_last;
    logic [N-1:0] m_req, m_pend;
    int           m_pot[N];

    logic [N-1:0] obs_valid, obs_won;
    int           obs_edge = 0;
    int           obs_count = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_li = 0; m_open = 0; exp_busy = 0;
        m_req = '0; m_pend = '0;
`ifdef LI_ROTATE_TIE_EN
        m_last = N - 1;
`else
        m_last = 0;
`endif
        for (int i = 0; i < N; i++) m_pot[i] = 0;
        exp_q.delete();
    endfunction

    // Highest potential among requesters; ties go to the first index in scan order.
    function automatic int pick_winner(input logic [N-1:0] mask);
        int start, best, i;
        bit found;
`ifdef LI_ROTATE_TIE_EN
        start = (m_last + 1) % N;
`else
        start = 0;
`endif
        found = 0; best = 0;
        for (int j = 0; j < N; j++) begin
            i = (start + j) % N;
            if (mask[i] && (!found || m_pot[i] > m_pot[best])) begin
                best = i; found = 1;
            end
        end
        return best;
    endfunction

    function automatic void model_step(input logic [N-1:0] s, input logic [N*W-1:0] b, input bit c);
        logic [N-1:0] comb;
        resp_t r;
        int w;
        if (c) begin
            m_li = 0; m_open = 0; m_req = '0; m_pend = '0; exp_busy = 0;
            return;
        end
        for (int i = 0; i < N; i++) if (s[i]) m_pot[i] = int'($signed(b[i*W +: W]));
        if (m_open) begin
            if (edge_no <= m_k + WAIT) m_req |= s;
            else if (edge_no < m_resp) m_pend |= s;
            else begin
                w = pick_winner(m_req);
                r.valid = m_req; r.won = '0; r.won[w] = 1'b1; r.winner = w;
                exp_q.push_back(r);
                m_li = 1; m_last = w; m_pend |= s; m_open = 0;
            end
        end else begin
            comb = s | m_pend;
            m_pend = '0;
            if (comb != '0) begin
                if (m_li) begin
                    r.valid = comb; r.won = '0; r.winner = m_last;
                    exp_q.push_back(r);
                end else begin
                    m_open = 1; m_k = edge_no; m_resp = edge_no + WAIT + N + 1; m_req = comb;
                end
            end
        end
        exp_busy = m_open;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else begin
            edge_no++;
            model_step(sl, pots, core);
        end
    end

    always @(negedge clk) begin
        resp_t r;
        if (rst_n) begin
            check("busy", longint'(busy), longint'(exp_busy));
            check("li", longint'(li), longint'(m_li));
            if (valid_li != '0) begin
                obs_valid = valid_li; obs_won = won_lost; obs_edge = edge_no; obs_count++;
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_resp: got valid_li %0h, expected none", valid_li);
                end else begin
                    r = exp_q.pop_front();
                    check("valid_li", longint'(valid_li), longint'(r.valid));
                    check("won_lost", longint'(won_lost), longint'(r.won));
                    check("winner_idx", longint'(winner_idx), longint'(r.winner));
                end
            end else if (won_lost != '0) begin
                vectors++; miscompares++;
                $display("FAIL won_unqualified: got won_lost %0h, expected 0", won_lost);
            end
            if (exp_q.size() != 0) begin
                vectors++; miscompares++;
                $display("FAIL missing_resp: got valid_li 0, expected %0h", exp_q[0].valid);
                exp_q.delete();
            end
        end
    end

    task automatic tick(input logic [N-1:0] s, input bit c);
        @(negedge clk);
        sl = s; core = c;
        @(posedge clk);
        #1;
        sl = '0; core = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 0);
    endtask

    task automatic wait_resp(input int budget, input string name);
        int start = obs_count;
        for (int i = 0; i < budget && obs_count == start; i++) tick('0, 0);
        if (obs_count == start) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: got no response, expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic set_pot(input int i, input int v);
        pots[i*W +: W] = W'(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_edge, cnt0;
        logic [N-1:0] s;
        logic [N-1:0] tie_exp;

        #3;
        check("rst_valid", longint'(valid_li), 0);
        check("rst_won", longint'(won_lost), 0);
        check("rst_li", longint'(li), 0);
        check("rst_busy", longint'(busy), 0);
`ifdef LI_ROTATE_TIE_EN
        check("rst_winner", longint'(winner_idx), N - 1);
`else
        check("rst_winner", longint'(winner_idx), 0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        idle(2);

        // single request and its latency
        set_pot(2, 100);
        tick(8'h04, 0); req_edge = edge_no;
        wait_resp(40, "single");
        check("t1_valid", longint'(obs_valid), 8'h04);
        check("t1_won", longint'(obs_won), 8'h04);
        check("t1_latency", obs_edge - req_edge, WAIT + N + 1);
        check("t1_li", longint'(li), 1);
        check("t1_winner", longint'(winner_idx), 2);

        // two requests merged in one window
        tick('0, 1);
        set_pot(1, 50); set_pot(5, 80);
        tick(8'h02, 0); tick('0, 0); tick(8'h20, 0);
        wait_resp(40, "merge");
        check("t2_valid", longint'(obs_valid), 8'h22);
        check("t2_won", longint'(obs_won), 8'h20);
        check("t2_winner", longint'(winner_idx), 5);

        // tie after neuron 4 last won
        tick('0, 1);
        set_pot(4, 7);
        tick(8'h10, 0);
        wait_resp(40, "prewin");
        tick('0, 1);
        set_pot(3, -20); set_pot(6, -20);
        tick(8'h48, 0);
        wait_resp(40, "tie");
`ifdef LI_ROTATE_TIE_EN
        tie_exp = 8'h40;
`else
        tie_exp = 8'h08;
`endif
        check("t3_valid", longint'(obs_valid), 8'h48);
        check("t3_won", longint'(obs_won), longint'(tie_exp));

        // late spiker in IDLE with li set
        tick(8'h80, 0); req_edge = edge_no;
        wait_resp(5, "late");
        check("t4_valid", longint'(obs_valid), 8'h80);
        check("t4_won", longint'(obs_won), 0);
        check("t4_edge", obs_edge, req_edge);

        // request during COMPARE answered after RESPOND
        tick('0, 1);
        set_pot(0, 9);
        tick(8'h01, 0); req_edge = edge_no;
        idle(WAIT);
        tick(8'h08, 0);
        wait_resp(40, "cmp_win");
        check("t5_won", longint'(obs_won), 8'h01);
        wait_resp(5, "cmp_pend");
        check("t5_pend_valid", longint'(obs_valid), 8'h08);
        check("t5_pend_won", longint'(obs_won), 0);
        check("t5_pend_edge", obs_edge - req_edge, WAIT + N + 2);

        // image restart mid-COMPARE
        tick('0, 1);
        tick(8'h02, 0);
        idle(WAIT + 3);
        cnt0 = obs_count;
        tick('0, 1);
        check("t6_li", longint'(li), 0);
        check("t6_busy", longint'(busy), 0);
        idle(N + 4);
        check("t6_no_resp", obs_count, cnt0);
        set_pot(4, -3);
        tick(8'h10, 0);
        wait_resp(40, "fresh");
        check("t6_valid", longint'(obs_valid), 8'h10);
        check("t6_won", longint'(obs_won), 8'h10);

        // async reset in COLLECT
        tick('0, 1);
        tick(8'h01, 0); tick(8'h04, 0);
        @(negedge clk); #2 rst_n = 0;
        #1;
        check("t7_valid", longint'(valid_li), 0);
        check("t7_li", longint'(li), 0);
        check("t7_busy", longint'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        cnt0 = obs_count;
        idle(WAIT + N + 6);
        check("t7_no_stale", obs_count, cnt0);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) set_pot(i, int'($urandom()));
                else set_pot(i, int'($urandom_range(0, 8)) - 4);
            end
            s = N'($urandom()) & N'($urandom()) & N'($urandom());
            if ($urandom_range(0, 2) != 0) s = '0;
            // requesters keep their potential stable while being scanned
            if (m_open && (edge_no + 1 > m_k + WAIT)) s &= ~m_req;
            tick(s, ($urandom_range(0, 79) == 0));
        end
        idle(WAIT + N + 6);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
